// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
// Optional parity support is selected by FIFO_UART_TX_PARITY_EN.
package fifo_uart_pkg;

  localparam int FRAME_BITS_BASE = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_START,
    ST_DATA,
    ST_STOP
`ifdef FIFO_UART_TX_PARITY_EN
    , ST_PARITY
`endif
  } tx_state_t;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while run is high.
// bit_tick marks the wrap cycle; tick_next marks the cycle before it.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic bit_tick,
  output logic tick_next
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt <= '0;
    end else if (bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick  = run && (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign tick_next = run && (cnt == CNT_W'(CLKS_PER_BIT - 2));

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter; start, LSB-first data, [even parity], stop.
// Latency: start bit 3 cycles after IDLE sees a non-empty FIFO; frame is (DATA_WIDTH+2[+1])*CLKS_PER_BIT.
// Backpressure: reads one byte per frame, only from IDLE with tx_enable high. Parity: FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]      bit_idx;
  logic                  timer_run;
  logic                  bit_tick;
  logic                  tick_next;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity_bit;
`endif

  assign timer_run = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP)
`ifdef FIFO_UART_TX_PARITY_EN
                  || (state == ST_PARITY)
`endif
                  ;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .reset     (reset),
    .run       (timer_run),
    .bit_tick  (bit_tick),
    .tick_next (tick_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      fifo_rd_en <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      fifo_rd_en <= 1'b0;
      tx_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (tx_enable && !fifo_empty) begin
            state      <= ST_FETCH;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_FETCH: state <= ST_LATCH;
        // Read data appears one cycle after the strobe, i.e. now.
        ST_LATCH: begin
          shreg   <= fifo_data;
          bit_idx <= '0;
          tx      <= 1'b0;
          state   <= ST_START;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_bit <= even_parity(32'(fifo_data));
`endif
        end
        ST_START: begin
          if (bit_tick) begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= ST_PARITY;
`else
              tx    <= 1'b1;
              state <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_tick) begin
            tx    <= 1'b1;
            state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          // Register the done pulse one cycle early so it lands on the wrap cycle.
          if (tick_next) tx_done <= 1'b1;
          if (bit_tick) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with a behavioural FIFO and a per-cycle frame model.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = DW + 3;
`else
  localparam int NBITS = DW + 2;
`endif
  localparam int FRAME = NBITS * CPB;

  logic          clk = 1'b0;
  logic          reset;
  logic          tx_enable;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd_en;
  logic          tx;
  logic          busy;
  logic          tx_done;

  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          hold_fifo;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  int rd_count     = 0;
  int done_count   = 0;
  int rd_empty_err = 0;
  int n_assert     = 0;
  int n_fail       = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DATA_WIDTH   (DW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_enable  (tx_enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  // 8-deep FIFO with one-cycle registered read; shares reset unless held.
  always @(posedge clk) begin
    if (reset && !hold_fifo) begin
      fifo_q.delete();
      fifo_data <= '0;
    end else begin
      if (fifo_rd_en && !reset) begin
        rd_count++;
        if (fifo_q.size() == 0) rd_empty_err++;
        else fifo_data <= fifo_q.pop_front();
      end
      if (wr_en && fifo_q.size() < 8) fifo_q.push_back(wr_data);
    end
    if (!reset && tx_done) done_count++;
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level of serial bit slot j of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= DW) return b[j-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (j == DW + 1) return (($countones(b) % 2) == 1);
`endif
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    exp_q.push_back(b);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, " start latency"}, n, 3);
  endtask

  // Called on the first start-bit cycle; ends on the idle cycle after STOP.
  task automatic sample_frame(input int drop_at, input string tag);
    logic [7:0] b;
    int tx_err = 0, done_err = 0, busy_err = 0;
    b = exp_q.pop_front();
    for (int c = 0; c < FRAME; c++) begin
      if (c == drop_at) tx_enable = 1'b0;
      if (tx !== exp_bit(b, c / CPB)) tx_err++;
      if (tx_done !== (c == FRAME - 1)) done_err++;
      if (busy !== 1'b1) busy_err++;
      @(negedge clk);
    end
    check({tag, " tx waveform errors"}, tx_err, 0);
    check({tag, " tx_done errors"}, done_err, 0);
    check({tag, " busy errors"}, busy_err, 0);
    check({tag, " idle tx"}, tx, 1);
    check({tag, " idle busy"}, busy, 0);
  endtask

  initial begin
    int r0, d0, lows, nb;
    reset     = 1'b1;
    hold_fifo = 1'b0;
    tx_enable = 1'b1;
    wr_en     = 1'b0;
    wr_data   = '0;
    @(negedge clk);

    // Reset with a non-empty FIFO and tx_enable high.
    hold_fifo = 1'b1;
    push(8'h55);
    for (int i = 0; i < 2; i++) begin
      check("reset tx", tx, 1);
      check("reset fifo_rd_en", fifo_rd_en, 0);
      check("reset busy", busy, 0);
      check("reset tx_done", tx_done, 0);
      @(negedge clk);
    end
    tx_enable = 1'b0;
    reset     = 1'b0;
    hold_fifo = 1'b0;

    // Disabled with data waiting: no reads, line idle.
    r0 = rd_count; lows = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("disabled reads", rd_count - r0, 0);
    check("disabled tx low cycles", lows, 0);

    tx_enable = 1'b1;
    wait_start("0x55");
    sample_frame(-1, "0x55");

    // Single byte 0x01.
    r0 = rd_count; d0 = done_count;
    push(8'h01);
    wait_start("0x01");
    sample_frame(-1, "0x01");
    check("0x01 reads", rd_count - r0, 1);
    check("0x01 done pulses", done_count - d0, 1);

    // Eight bytes fill the FIFO, then drain back-to-back.
    tx_enable = 1'b0;
    r0 = rd_count; d0 = done_count;
    push(8'h01); push(8'h09); push(8'h07); push(8'h03);
    push(8'h04); push(8'h06); push(8'h08); push(8'h0A);
    tx_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_start("burst");
      sample_frame(-1, "burst");
    end
    check("burst reads", rd_count - r0, 8);
    check("burst done pulses", done_count - d0, 8);
    check("burst fifo_empty", fifo_empty, 1);
    repeat (20) @(negedge clk);
    check("burst no 9th read", rd_count - r0, 8);

    // Random bytes.
    tx_enable = 1'b0;
    r0 = rd_count;
    nb = $urandom_range(3, 7);
    for (int i = 0; i < nb; i++) push(8'($urandom_range(0, 255)));
    tx_enable = 1'b1;
    for (int i = 0; i < nb; i++) begin
      wait_start("random");
      sample_frame(-1, "random");
    end
    check("random reads", rd_count - r0, nb);

    // tx_enable dropped during DATA of 0x09.
    tx_enable = 1'b0;
    push(8'h09); push(8'h0A);
    tx_enable = 1'b1;
    wait_start("0x09");
    sample_frame(CPB * 3, "0x09 drop");
    r0 = rd_count; lows = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("drop no further read", rd_count - r0, 0);
    check("drop tx low cycles", lows, 0);
    check("drop fifo still holds 0x0A", fifo_empty, 0);

    // Reset during data bit 3 of 0x0A.
    tx_enable = 1'b1;
    wait_start("0x0A");
    repeat (CPB * 4 + 1) @(negedge clk);
    check("0x0A bit3 level", tx, exp_bit(8'h0A, 4));
    reset = 1'b1;
    @(negedge clk);
    check("abort tx", tx, 1);
    check("abort busy", busy, 0);
    check("abort tx_done", tx_done, 0);
    reset = 1'b0;
    void'(exp_q.pop_front());
    r0 = rd_count;
    repeat (30) @(negedge clk);
    check("post-abort reads", rd_count - r0, 0);
    check("post-abort fifo_empty", fifo_empty, 1);
    check("post-abort tx", tx, 1);
    check("reads while empty", rd_empty_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
